// File: rtl/cache_assoc_store_if.sv
// cache_assoc_store_if: request, fill, invalidate and response bundle of the line store.
// master = cache controller side, slave = line store side.
interface cache_assoc_store_if #(
    parameter int NUM_WAYS = 2,
    parameter int S_INDEX  = 3,
    parameter int S_TAG    = 24,
    parameter int S_LINE   = 256
);
    localparam int S_MASK = S_LINE / 8;
    localparam int S_WAY  = $clog2(NUM_WAYS);

    logic               req_valid;
    logic               req_write;
    logic [S_INDEX-1:0] req_index;
    logic [S_TAG-1:0]   req_tag;
    logic [S_MASK-1:0]  req_wmask;
    logic [S_LINE-1:0]  req_wdata;
    logic               req_ready;

    logic               fill_valid;
    logic [S_INDEX-1:0] fill_index;
    logic [S_TAG-1:0]   fill_tag;
    logic [S_LINE-1:0]  fill_data;
    logic               fill_dirty;
    logic               fill_ready;

    logic               inv_valid;
    logic [S_INDEX-1:0] inv_index;

    logic               rsp_valid;
    logic               rsp_hit;
    logic [S_WAY-1:0]   rsp_way;
    logic [S_LINE-1:0]  rsp_rdata;
    logic               victim_valid;
    logic               victim_dirty;
    logic [S_TAG-1:0]   victim_tag;
    logic [S_LINE-1:0]  victim_data;

    modport master (
        output req_valid, req_write, req_index, req_tag, req_wmask, req_wdata,
        input  req_ready,
        output fill_valid, fill_index, fill_tag, fill_data, fill_dirty,
        input  fill_ready,
        output inv_valid, inv_index,
        input  rsp_valid, rsp_hit, rsp_way, rsp_rdata,
        input  victim_valid, victim_dirty, victim_tag, victim_data
    );

    modport slave (
        input  req_valid, req_write, req_index, req_tag, req_wmask, req_wdata,
        output req_ready,
        input  fill_valid, fill_index, fill_tag, fill_data, fill_dirty,
        output fill_ready,
        input  inv_valid, inv_index,
        output rsp_valid, rsp_hit, rsp_way, rsp_rdata,
        output victim_valid, victim_dirty, victim_tag, victim_data
    );
endinterface

// File: rtl/cache_assoc_store.sv
// cache_assoc_store: N-way set-associative line store with per-set tree PLRU.
// Ports: clk; rst (sync, active-low); bus (slave): req_* lookup/masked write,
//   fill_* install into victim way, inv_* set invalidate, rsp_*/victim_* registered response.
module cache_assoc_store #(
    parameter int NUM_WAYS = 2,
    parameter int S_INDEX  = 3,
    parameter int S_TAG    = 24,
    parameter int S_LINE   = 256,
    parameter int S_MASK   = S_LINE / 8,
    parameter int S_WAY    = $clog2(NUM_WAYS)
) (
    input logic                clk,
    input logic                rst,
    cache_assoc_store_if.slave bus
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int NODES = NUM_WAYS - 1;

    typedef logic [S_INDEX-1:0]  idx_t;
    typedef logic [S_TAG-1:0]    tag_t;
    typedef logic [S_LINE-1:0]   line_t;
    typedef logic [S_WAY-1:0]    way_t;
    typedef logic [NUM_WAYS-1:0] wvec_t;
    typedef logic [NODES-1:0]    plru_t;

    wvec_t valid_q [SETS];
    wvec_t valid_d [SETS];
    wvec_t dirty_q [SETS];
    wvec_t dirty_d [SETS];
    plru_t plru_q  [SETS];
    plru_t plru_d  [SETS];
    tag_t  tag_q   [SETS][NUM_WAYS];
    tag_t  tag_d   [SETS][NUM_WAYS];
    line_t data_q  [SETS][NUM_WAYS];
    line_t data_d  [SETS][NUM_WAYS];

    logic  rsp_valid_q, rsp_valid_d;
    logic  rsp_hit_q, rsp_hit_d;
    way_t  rsp_way_q, rsp_way_d;
    line_t rsp_rdata_q, rsp_rdata_d;
    logic  victim_valid_q, victim_valid_d;
    logic  victim_dirty_q, victim_dirty_d;
    tag_t  victim_tag_q, victim_tag_d;
    line_t victim_data_q, victim_data_d;

    logic  inv_acc, fill_acc, req_acc;
    idx_t  op_index;
    wvec_t set_valid, set_dirty, hit_vec;
    plru_t set_plru;
    logic  hit;
    way_t  hit_way, victim_way, sel_way;
    line_t merged;

    // Lowest invalid way wins; otherwise walk the tree (0 = left, 1 = right).
    function automatic way_t pick_victim(input wvec_t v, input plru_t p);
        way_t w;
        logic found;
        int   node;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!found && !v[i]) begin
                found = 1'b1;
                w     = way_t'(i);
            end
        end
        if (!found) begin
            node = 0;
            for (int l = 0; l < S_WAY; l++) begin
                node = 2 * node + 1 + int'(p[node]);
            end
            w = way_t'(node - NODES);
        end
        return w;
    endfunction

    // Each node on the path to w is flipped to point at the other subtree.
    function automatic plru_t touch(input plru_t p, input way_t w);
        plru_t r;
        int    node;
        logic  dir;
        r    = p;
        node = 0;
        for (int l = 0; l < S_WAY; l++) begin
            dir     = w[S_WAY-1-l];
            r[node] = ~dir;
            node    = 2 * node + 1 + int'(dir);
        end
        return r;
    endfunction

    assign bus.fill_ready = !bus.inv_valid;
    assign bus.req_ready  = !bus.inv_valid && !bus.fill_valid;

    assign inv_acc  = bus.inv_valid;
    assign fill_acc = bus.fill_valid && !bus.inv_valid;
    assign req_acc  = bus.req_valid && !bus.inv_valid && !bus.fill_valid;

    // A fill and a request are never both accepted, so one lookup serves both.
    assign op_index  = bus.fill_valid ? bus.fill_index : bus.req_index;
    assign set_valid = valid_q[op_index];
    assign set_dirty = dirty_q[op_index];
    assign set_plru  = plru_q[op_index];

    always_comb begin : lookup
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = set_valid[w] && (tag_q[op_index][w] == bus.req_tag);
            if (hit_vec[w]) begin
                hit_way = way_t'(w);
            end
        end
    end

    assign hit        = |hit_vec;
    assign victim_way = pick_victim(set_valid, set_plru);
    assign sel_way    = hit ? hit_way : victim_way;

    always_comb begin : byte_merge
        merged = data_q[op_index][hit_way];
        for (int b = 0; b < S_MASK; b++) begin
            if (bus.req_wmask[b]) begin
                merged[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin : next_state
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        plru_d         = plru_q;
        tag_d          = tag_q;
        data_d         = data_q;
        rsp_valid_d    = 1'b0;
        rsp_hit_d      = rsp_hit_q;
        rsp_way_d      = rsp_way_q;
        rsp_rdata_d    = rsp_rdata_q;
        victim_valid_d = victim_valid_q;
        victim_dirty_d = victim_dirty_q;
        victim_tag_d   = victim_tag_q;
        victim_data_d  = victim_data_q;
        if (inv_acc) begin
            // Tag and data stay; only state bits are cleared.
            valid_d[bus.inv_index] = '0;
            dirty_d[bus.inv_index] = '0;
            plru_d[bus.inv_index]  = '0;
        end else if (fill_acc) begin
            valid_d[bus.fill_index][victim_way] = 1'b1;
            dirty_d[bus.fill_index][victim_way] = bus.fill_dirty;
            tag_d[bus.fill_index][victim_way]   = bus.fill_tag;
            data_d[bus.fill_index][victim_way]  = bus.fill_data;
            plru_d[bus.fill_index] = touch(set_plru, victim_way);
        end else if (req_acc) begin
            rsp_valid_d    = 1'b1;
            rsp_hit_d      = hit;
            rsp_way_d      = sel_way;
            rsp_rdata_d    = data_q[op_index][sel_way];
            victim_valid_d = set_valid[victim_way];
            victim_dirty_d = set_dirty[victim_way];
            victim_tag_d   = tag_q[op_index][victim_way];
            victim_data_d  = data_q[op_index][victim_way];
            if (hit) begin
                plru_d[bus.req_index] = touch(set_plru, hit_way);
                if (bus.req_write && |bus.req_wmask) begin
                    data_d[bus.req_index][hit_way]  = merged;
                    dirty_d[bus.req_index][hit_way] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_way_q      <= '0;
            rsp_rdata_q    <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            victim_tag_q   <= '0;
            victim_data_q  <= '0;
        end else begin
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            plru_q         <= plru_d;
            tag_q          <= tag_d;
            data_q         <= data_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_way_q      <= rsp_way_d;
            rsp_rdata_q    <= rsp_rdata_d;
            victim_valid_q <= victim_valid_d;
            victim_dirty_q <= victim_dirty_d;
            victim_tag_q   <= victim_tag_d;
            victim_data_q  <= victim_data_d;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_hit      = rsp_hit_q;
    assign bus.rsp_way      = rsp_way_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_dirty = victim_dirty_q;
    assign bus.victim_tag   = victim_tag_q;
    assign bus.victim_data  = victim_data_q;
endmodule

// File: tb/tb_cache_assoc_store.sv
// tb_cache_assoc_store: 2-way and 4-way line stores against a behavioural set model.
// Directed scenarios first, then randomized operation mixes on both instances.
module tb_cache_assoc_store;
    localparam int IW = 3;
    localparam int TW = 24;
    localparam int LW = 256;
    localparam int MW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_n;
    logic [1:0]    req_valid, req_write, fill_valid, fill_dirty, inv_valid;
    logic [IW-1:0] req_index [2];
    logic [IW-1:0] fill_index [2];
    logic [IW-1:0] inv_index [2];
    logic [TW-1:0] req_tag [2];
    logic [TW-1:0] fill_tag [2];
    logic [MW-1:0] req_wmask [2];
    logic [LW-1:0] req_wdata [2];
    logic [LW-1:0] fill_data [2];

    logic [1:0]    o_rready, o_fready, o_rvalid, o_hit, o_vvalid, o_vdirty;
    logic [1:0]    o_way [2];
    logic [TW-1:0] o_vtag [2];
    logic [LW-1:0] o_rdata [2];
    logic [LW-1:0] o_vdata [2];

    cache_assoc_store_if #(.NUM_WAYS(2)) if2 ();
    cache_assoc_store_if #(.NUM_WAYS(4)) if4 ();

    cache_assoc_store #(.NUM_WAYS(2)) u_dut2 (.clk(clk), .rst(rst_n[0]), .bus(if2));
    cache_assoc_store #(.NUM_WAYS(4)) u_dut4 (.clk(clk), .rst(rst_n[1]), .bus(if4));

    assign if2.req_valid  = req_valid[0];
    assign if2.req_write  = req_write[0];
    assign if2.req_index  = req_index[0];
    assign if2.req_tag    = req_tag[0];
    assign if2.req_wmask  = req_wmask[0];
    assign if2.req_wdata  = req_wdata[0];
    assign if2.fill_valid = fill_valid[0];
    assign if2.fill_index = fill_index[0];
    assign if2.fill_tag   = fill_tag[0];
    assign if2.fill_data  = fill_data[0];
    assign if2.fill_dirty = fill_dirty[0];
    assign if2.inv_valid  = inv_valid[0];
    assign if2.inv_index  = inv_index[0];
    assign o_rready[0]    = if2.req_ready;
    assign o_fready[0]    = if2.fill_ready;
    assign o_rvalid[0]    = if2.rsp_valid;
    assign o_hit[0]       = if2.rsp_hit;
    assign o_way[0]       = 2'(if2.rsp_way);
    assign o_rdata[0]     = if2.rsp_rdata;
    assign o_vvalid[0]    = if2.victim_valid;
    assign o_vdirty[0]    = if2.victim_dirty;
    assign o_vtag[0]      = if2.victim_tag;
    assign o_vdata[0]     = if2.victim_data;

    assign if4.req_valid  = req_valid[1];
    assign if4.req_write  = req_write[1];
    assign if4.req_index  = req_index[1];
    assign if4.req_tag    = req_tag[1];
    assign if4.req_wmask  = req_wmask[1];
    assign if4.req_wdata  = req_wdata[1];
    assign if4.fill_valid = fill_valid[1];
    assign if4.fill_index = fill_index[1];
    assign if4.fill_tag   = fill_tag[1];
    assign if4.fill_data  = fill_data[1];
    assign if4.fill_dirty = fill_dirty[1];
    assign if4.inv_valid  = inv_valid[1];
    assign if4.inv_index  = inv_index[1];
    assign o_rready[1]    = if4.req_ready;
    assign o_fready[1]    = if4.fill_ready;
    assign o_rvalid[1]    = if4.rsp_valid;
    assign o_hit[1]       = if4.rsp_hit;
    assign o_way[1]       = if4.rsp_way;
    assign o_rdata[1]     = if4.rsp_rdata;
    assign o_vvalid[1]    = if4.victim_valid;
    assign o_vdirty[1]    = if4.victim_dirty;
    assign o_vtag[1]      = if4.victim_tag;
    assign o_vdata[1]     = if4.victim_data;

    int n_checks;
    int n_fail;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain per-way state plus PLRU node bits per set.
    int            nw [2];
    bit            m_valid [2][8][4];
    bit            m_dirty [2][8][4];
    logic [TW-1:0] m_tag [2][8][4];
    logic [LW-1:0] m_data [2][8][4];
    bit            m_plru [2][8][3];
    bit            e_rv [2];
    bit            e_hit [2];
    bit            e_vv [2];
    bit            e_vd [2];
    int            e_way [2];
    logic [TW-1:0] e_vt [2];
    logic [LW-1:0] e_rd [2];
    logic [LW-1:0] e_vdat [2];

    function automatic void m_reset(input int d);
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[d][s][w] = 1'b0;
                m_dirty[d][s][w] = 1'b0;
                m_tag[d][s][w]   = '0;
                m_data[d][s][w]  = '0;
            end
            for (int n = 0; n < 3; n++) m_plru[d][s][n] = 1'b0;
        end
        e_rv[d] = 1'b0; e_hit[d] = 1'b0; e_vv[d] = 1'b0; e_vd[d] = 1'b0;
        e_way[d] = 0; e_vt[d] = '0; e_rd[d] = '0; e_vdat[d] = '0;
    endfunction

    function automatic int m_victim(input int d, input int s);
        int n;
        for (int w = 0; w < nw[d]; w++) begin
            if (!m_valid[d][s][w]) return w;
        end
        n = 0;
        while (n < nw[d] - 1) n = 2 * n + 1 + int'(m_plru[d][s][n]);
        return n - (nw[d] - 1);
    endfunction

    // Climb from the leaf; each parent points at the sibling subtree.
    function automatic void m_touch(input int d, input int s, input int w);
        int leaf;
        int par;
        leaf = w + nw[d] - 1;
        while (leaf > 0) begin
            par = (leaf - 1) / 2;
            m_plru[d][s][par] = (leaf == 2 * par + 1);
            leaf = par;
        end
    endfunction

    function automatic bit tag_present(input int d, input int s, input int t);
        for (int w = 0; w < nw[d]; w++) begin
            if (m_valid[d][s][w] && m_tag[d][s][w] == TW'(t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input int d);
        bit iv, fv, rv;
        int s, v, hw;
        iv = inv_valid[d];
        fv = fill_valid[d];
        rv = req_valid[d];
        #1;
        chk("req_ready", o_rready[d], !iv && !fv);
        chk("fill_ready", o_fready[d], !iv);
        e_rv[d] = 1'b0;
        if (!rst_n[d]) begin
            m_reset(d);
        end else if (iv) begin
            s = int'(inv_index[d]);
            for (int w = 0; w < 4; w++) begin
                m_valid[d][s][w] = 1'b0;
                m_dirty[d][s][w] = 1'b0;
            end
            for (int n = 0; n < 3; n++) m_plru[d][s][n] = 1'b0;
        end else if (fv) begin
            s = int'(fill_index[d]);
            v = m_victim(d, s);
            m_valid[d][s][v] = 1'b1;
            m_dirty[d][s][v] = fill_dirty[d];
            m_tag[d][s][v]   = fill_tag[d];
            m_data[d][s][v]  = fill_data[d];
            m_touch(d, s, v);
        end else if (rv) begin
            s  = int'(req_index[d]);
            hw = -1;
            for (int w = 0; w < nw[d]; w++) begin
                if (m_valid[d][s][w] && m_tag[d][s][w] == req_tag[d]) hw = w;
            end
            v         = m_victim(d, s);
            e_rv[d]   = 1'b1;
            e_hit[d]  = (hw >= 0);
            e_way[d]  = e_hit[d] ? hw : v;
            e_rd[d]   = m_data[d][s][e_way[d]];
            e_vv[d]   = m_valid[d][s][v];
            e_vd[d]   = m_dirty[d][s][v];
            e_vt[d]   = m_tag[d][s][v];
            e_vdat[d] = m_data[d][s][v];
            if (e_hit[d]) begin
                m_touch(d, s, hw);
                if (req_write[d] && req_wmask[d] != '0) begin
                    for (int b = 0; b < MW; b++) begin
                        if (req_wmask[d][b]) m_data[d][s][hw][8*b +: 8] = req_wdata[d][8*b +: 8];
                    end
                    m_dirty[d][s][hw] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        fill_valid[d] = 1'b0;
        inv_valid[d]  = 1'b0;
        rst_n[d]      = 1'b1;
        chk("rsp_valid", o_rvalid[d], e_rv[d]);
        chk("rsp_hit", o_hit[d], e_hit[d]);
        chk("rsp_way", o_way[d], e_way[d]);
        chk("rsp_rdata", o_rdata[d], e_rd[d]);
        if (!e_hit[d]) begin
            chk("victim_valid", o_vvalid[d], e_vv[d]);
            chk("victim_dirty", o_vdirty[d], e_vd[d]);
            chk("victim_tag", o_vtag[d], e_vt[d]);
            chk("victim_data", o_vdata[d], e_vdat[d]);
        end
    endtask

    task automatic rd(input int d, input int idx, input logic [TW-1:0] tag);
        req_valid[d] = 1'b1; req_write[d] = 1'b0;
        req_index[d] = IW'(idx); req_tag[d] = tag;
        step(d);
    endtask

    task automatic wr(input int d, input int idx, input logic [TW-1:0] tag,
                      input logic [MW-1:0] mask, input logic [LW-1:0] wd);
        req_valid[d] = 1'b1; req_write[d] = 1'b1;
        req_index[d] = IW'(idx); req_tag[d] = tag;
        req_wmask[d] = mask; req_wdata[d] = wd;
        step(d);
    endtask

    task automatic fl(input int d, input int idx, input logic [TW-1:0] tag,
                      input logic [LW-1:0] dat, input bit dty);
        fill_valid[d] = 1'b1; fill_index[d] = IW'(idx);
        fill_tag[d] = tag; fill_data[d] = dat; fill_dirty[d] = dty;
        step(d);
    endtask

    task automatic rand_phase(input int d, input int n);
        int r, t, m;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            inv_valid[d]  = (r < 6);
            fill_valid[d] = (r >= 4 && r < 30);
            req_valid[d]  = (r >= 26);
            rst_n[d]      = ($urandom_range(0, 199) != 0);
            inv_index[d]  = IW'($urandom_range(0, 3));
            fill_index[d] = IW'($urandom_range(0, 3));
            req_index[d]  = IW'($urandom_range(0, 3));
            req_write[d]  = 1'($urandom_range(0, 1));
            req_tag[d]    = TW'($urandom_range(1, 8));
            m = $urandom_range(0, 2);
            req_wmask[d]  = (m == 0) ? '0 : (m == 1) ? '1 : MW'($urandom());
            req_wdata[d]  = {8{$urandom()}};
            do t = $urandom_range(1, 8);
            while (tag_present(d, int'(fill_index[d]), t));
            fill_tag[d]   = TW'(t);
            fill_data[d]  = {8{$urandom()}};
            fill_dirty[d] = 1'($urandom_range(0, 1));
            step(d);
        end
    endtask

    logic [LW-1:0] l55, laa, lff, lexp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nw[0] = 2;
        nw[1] = 4;
        l55 = {32{8'h55}};
        laa = {32{8'haa}};
        lff = '1;
        rst_n = 2'b00;
        req_valid = '0; req_write = '0; fill_valid = '0; fill_dirty = '0; inv_valid = '0;
        for (int d = 0; d < 2; d++) begin
            req_index[d] = '0; fill_index[d] = '0; inv_index[d] = '0;
            req_tag[d] = '0; fill_tag[d] = '0; req_wmask[d] = '0;
            req_wdata[d] = '0; fill_data[d] = '0;
            m_reset(d);
        end
        // A request presented during reset must be dropped.
        req_valid[0] = 1'b1; req_index[0] = 3'd3; req_tag[0] = 24'h000011;
        step(0);
        chk("rst_drop", o_rvalid[0], 1'b0);
        step(1);

        rd(0, 3, 24'habcdef);
        chk("p1_hit", o_hit[0], 1'b0);
        chk("p1_way", o_way[0], 2'd0);
        chk("p1_vvalid", o_vvalid[0], 1'b0);
        chk("p1_rdata", o_rdata[0], '0);

        fl(0, 3, 24'h000011, l55, 1'b0);
        fl(0, 3, 24'h000022, laa, 1'b0);
        rd(0, 3, 24'h000022);
        chk("p2_hit", o_hit[0], 1'b1);
        chk("p2_way", o_way[0], 2'd1);
        fl(0, 3, 24'h000033, l55, 1'b0);
        rd(0, 3, 24'h000033);
        chk("p2_lru_way", o_way[0], 2'd0);
        rd(0, 3, 24'h000011);
        chk("p2_evicted", o_hit[0], 1'b0);

        wr(0, 3, 24'h000033, 32'h0000000f, lff);
        chk("p3_old", o_rdata[0], l55);
        rd(0, 3, 24'h000033);
        lexp = {l55[LW-1:32], 32'hffffffff};
        chk("p3_new", o_rdata[0], lexp);
        rd(0, 3, 24'h000022);
        rd(0, 3, 24'h000044);
        chk("p3_vway", o_way[0], 2'd0);
        chk("p3_vdirty", o_vdirty[0], 1'b1);

        wr(0, 3, 24'h000022, 32'h0, lff);
        rd(0, 3, 24'h000033);
        rd(0, 3, 24'h000044);
        chk("p4_vway", o_way[0], 2'd1);
        chk("p4_vdirty", o_vdirty[0], 1'b0);
        chk("p4_vdata", o_vdata[0], laa);
        wr(0, 3, 24'h000077, '1, lff);
        chk("p4_wmiss", o_hit[0], 1'b0);
        rd(0, 3, 24'h000033);
        chk("p4_unchanged", o_rdata[0], lexp);

        fl(0, 5, 24'h000066, laa, 1'b1);
        inv_valid[0] = 1'b1; inv_index[0] = 3'd5;
        fill_valid[0] = 1'b1; fill_index[0] = 3'd5; fill_tag[0] = 24'h000099;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_index[0] = 3'd5; req_tag[0] = 24'h000066;
        step(0);
        chk("p5_no_rsp", o_rvalid[0], 1'b0);
        rd(0, 5, 24'h000066);
        chk("p5_inv_hit", o_hit[0], 1'b0);
        chk("p5_inv_vvalid", o_vvalid[0], 1'b0);
        rd(0, 5, 24'h000099);
        chk("p5_fill_dropped", o_hit[0], 1'b0);

        for (int t = 1; t <= 4; t++) fl(1, 1, TW'(t), {8{$urandom()}}, 1'b0);
        rd(1, 1, 24'd1);
        rd(1, 1, 24'd3);
        rd(1, 1, 24'd2);
        chk("p6_way1", o_way[1], 2'd1);
        fl(1, 1, 24'd5, l55, 1'b0);
        rd(1, 1, 24'd5);
        chk("p6_victim3", o_way[1], 2'd3);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_index[1] = 3'd1; req_tag[1] = 24'd5;
        rst_n[1] = 1'b0;
        step(1);
        chk("p6_rst_rsp", o_rvalid[1], 1'b0);
        for (int s = 0; s < 8; s++) begin
            rd(1, s, 24'd5);
            chk("p6_rst_vvalid", o_vvalid[1], 1'b0);
        end

        rand_phase(0, 600);
        rand_phase(1, 600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_assoc_store.md
Name: cache_assoc_store

Overview:
- Parametrised N-way set-associative line store: valid, dirty, tag and data arrays per way, plus per-set tree pseudo-LRU state.
- Generalises the single-way storage block with configurable way count, set count, tag width and line width.
- Adds registered hit detection, byte-masked write-hit update, victim selection and fill, and set invalidation.
- Sits between the cache controller FSM and the cacheline adaptor. The controller issues one operation per cycle and uses the registered response and victim info to decide on writeback and fill.

Parameters:
- NUM_WAYS, 2, number of ways; power of two, at least 2.
- S_INDEX, 3, index bits; sets = 2**S_INDEX.
- S_TAG, 24, tag width.
- S_LINE, 256, line width in bits; multiple of 8.
- S_MASK, S_LINE/8, byte-enable width (derived).
- S_WAY, log2(NUM_WAYS), way-number width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  lookup/access request.
- req_write  in  1  1 = masked write on hit; 0 = read.
- req_index  in  S_INDEX  set index.
- req_tag  in  S_TAG  compare tag.
- req_wmask  in  S_MASK  byte enables; bit i covers data bits [8i+7:8i].
- req_wdata  in  S_LINE  write data.
- req_ready  out  1  = !inv_valid && !fill_valid (combinational).
- fill_valid  in  1  install a line into the victim way of fill_index.
- fill_index  in  S_INDEX  fill set.
- fill_tag  in  S_TAG  fill tag.
- fill_data  in  S_LINE  fill line.
- fill_dirty  in  1  dirty value for the installed line.
- fill_ready  out  1  = !inv_valid (combinational).
- inv_valid  in  1  invalidate every way of inv_index.
- inv_index  in  S_INDEX  set to invalidate.
- rsp_valid  out  1  pulses the cycle after an accepted request.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  S_WAY  hit way on a hit; victim way on a miss.
- rsp_rdata  out  S_LINE  line of rsp_way before any write this op.
- victim_valid, victim_dirty  out  1 each  state of the victim way (meaningful when rsp_hit=0).
- victim_tag  out  S_TAG  tag of the victim way.
- victim_data  out  S_LINE  data of the victim way.

Behaviour:
- Reset (rst=0 at an edge): all valid, dirty, tag, data and PLRU bits clear. All rsp_* and victim_* outputs go to 0. Any operation presented in that cycle is dropped, with no response.
- Operation priority each cycle: inv > fill > req. A request accepted when req_valid && req_ready; a fill accepted when fill_valid && fill_ready. Non-accepted operations have no side effects.
- Arrays are flop-based and read combinationally in the accept cycle T. All array, PLRU and response-register updates occur at the edge ending T.
- Response latency: 1 cycle. rsp_valid=1 in T+1 only. rsp_* and victim_* hold their values until the next accepted request. Back-to-back requests to the same set see prior updates; no hazard.
- Hit: some way w has valid=1 and tag==req_tag. Tags are unique per set, guaranteed by the controller.
  - rsp_hit=1, rsp_way=w, rsp_rdata=old data.
  - Write hit: bytes with wmask=1 are replaced. dirty[w] is set only if wmask != 0. An all-zero mask changes no state except PLRU.
  - Any hit: PLRU touched for w.
- Miss:
  - rsp_hit=0, rsp_way=victim, rsp_rdata=victim_data. No array or PLRU change; a write miss is a no-op.
  - Victim = lowest-numbered invalid way if any, else the PLRU way.
- Fill: victim computed as on a miss, for fill_index. Writes valid=1, dirty=fill_dirty, tag, data. PLRU touched for that way. Existing contents are overwritten; the controller must already have written back a dirty victim.
- Invalidate: valid=0 and dirty=0 for all ways of the set; the set's PLRU cleared to 0. Tag and data are retained.
- PLRU: NUM_WAYS-1 bits per set in heap order (node n has children 2n+1 and 2n+2; leaves map to ways 0..N-1 left to right).
  - Victim walk: bit=0 goes left, bit=1 goes right.
  - Touching way w: every node on w's path is set to point away from w.
- Simultaneous fill and request to the same set: the request is not ready, so there is no conflict.

Test Plan:
- Reset then read idx 3, tag 0xABCDEF (NUM_WAYS=2) -> T+1: rsp_valid=1, hit=0, way=0, victim_valid=0, all data 0.
- Fill idx 3 tag 0x000011 data 0x55..55, then fill idx 3 tag 0x000022; read tag 0x22 -> hit=1, way=1. A third fill, tag 0x33, replaces way 0 (LRU).
- Write hit, wmask=0x0000000F, wdata=0xFFFF..FF, on a line of 0x55..55 -> rsp_rdata=old line. Re-read: low 32 bits 0xFFFFFFFF, rest 0x55. The miss report for that way shows victim_dirty=1.
- Write hit with wmask=0 -> dirty stays 0. Write miss -> all arrays unchanged (verify by re-read).
- fill_valid, req_valid and inv_valid asserted together on idx 5 -> only the invalidate takes effect; req_ready=0 and fill_ready=0; no rsp_valid next cycle; the set reads all-invalid.
- NUM_WAYS=4: fill ways 0..3, access 0, 2, 1 -> next fill victim is way 3. Then assert rst=0 mid-stream -> next cycle rsp_valid=0 and all sets are invalid.
